// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmitter.
//   tx_state_e    : transmitter FSM states (PARITY only with UART_TX_PARITY_EN)
//   DataBits      : data bits per frame
//   MinClksPerBit : smallest usable bit period; smaller requests are clamped
package uart_tx_pkg;

    localparam int unsigned DataBits      = 8;
    localparam int unsigned MinClksPerBit = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_transmitter_if.sv
// Producer-side byte handshake of the UART transmitter.
//   tx_valid_i : producer has a byte
//   tx_byte_i  : byte to send
//   tx_ready_o : transmitter can accept a byte this cycle
// master = producer, slave = transmitter.
interface uart_transmitter_if;

    logic       tx_valid_i;
    logic [7:0] tx_byte_i;
    logic       tx_ready_o;

    modport master (
        output tx_valid_i,
        output tx_byte_i,
        input  tx_ready_o
    );

    modport slave (
        input  tx_valid_i,
        input  tx_byte_i,
        output tx_ready_o
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter.
//   clk_i     : clock
//   rst_ni    : synchronous active-high reset (clears pointers and count)
//   push      : write push_data (ignored when full)
//   push_data : byte to write
//   pop       : remove the head entry (ignored when empty)
//   pop_data  : head entry, valid while !empty
//   full      : count == FifoDepth
//   empty     : count == 0
// FifoDepth must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
    parameter int unsigned FifoDepth = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = PtrW + 1;

    logic [7:0]      mem [FifoDepth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    logic            do_push;
    logic            do_pop;

    assign full     = (count == CntW'(FifoDepth));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// Byte-serial UART transmitter, 8N1, LSB first, with a small input FIFO.
//   clk_i        : system clock
//   rst_ni       : synchronous active-high reset (name pairs with uart_receiver)
//   CLKS_PER_BIT : clock cycles per bit, latched at frame start, clamped to >= 2
//   tx_if        : producer handshake (slave modport)
//   tx_serial_o  : serial line, idles high, driven from a flop
//   tx_busy_o    : frame in progress or FIFO non-empty
//   tx_done_o    : pulse on the last cycle of each stop bit
// Build option UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_transmitter
    import uart_tx_pkg::*;
#(
    parameter int unsigned FifoDepth = 4,
    parameter int unsigned CntW      = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [CntW-1:0] CLKS_PER_BIT,
    uart_transmitter_if.slave tx_if,
    output logic            tx_serial_o,
    output logic            tx_busy_o,
    output logic            tx_done_o
);

    localparam int unsigned IdxW = $clog2(DataBits);

    tx_state_e           state, next_state;
    logic [CntW-1:0]     cnt, cnt_next;
    logic [CntW-1:0]     period, period_next;
    logic [IdxW-1:0]     bit_idx, bit_idx_next;
    logic [DataBits-1:0] shift, shift_next;
    logic                serial, serial_next;
`ifdef UART_TX_PARITY_EN
    logic                parity, parity_next;
`endif

    logic            fifo_pop;
    logic [7:0]      fifo_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic            load_frame;
    logic            bit_last;
    logic [CntW-1:0] clks_clamped;

    uart_tx_fifo #(
        .FifoDepth (FifoDepth)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (tx_if.tx_valid_i),
        .push_data (tx_if.tx_byte_i),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign tx_if.tx_ready_o = ~fifo_full;
    assign tx_busy_o        = (state != IDLE) | ~fifo_empty;
    assign tx_serial_o      = serial;

    assign clks_clamped = (CLKS_PER_BIT < CntW'(MinClksPerBit)) ? CntW'(MinClksPerBit)
                                                                 : CLKS_PER_BIT;
    assign bit_last     = (cnt == period - CntW'(1));

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            state   <= IDLE;
            cnt     <= '0;
            period  <= '0;
            bit_idx <= '0;
            shift   <= '0;
            serial  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            state   <= next_state;
            cnt     <= cnt_next;
            period  <= period_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            serial  <= serial_next;
`ifdef UART_TX_PARITY_EN
            parity  <= parity_next;
`endif
        end
    end

    always_comb begin
        next_state   = state;
        cnt_next     = cnt + CntW'(1);
        period_next  = period;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        fifo_pop     = 1'b0;
        load_frame   = 1'b0;
        tx_done_o    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity;
`endif

        unique case (state)
            IDLE: begin
                cnt_next = '0;
                if (!fifo_empty) begin
                    load_frame = 1'b1;
                end
            end
            START: begin
                if (bit_last) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    next_state   = DATA;
                end
            end
            DATA: begin
                if (bit_last) begin
                    cnt_next   = '0;
                    shift_next = shift >> 1;
                    if (bit_idx == IdxW'(DataBits - 1)) begin
`ifdef UART_TX_PARITY_EN
                        next_state = PARITY;
`else
                        next_state = STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx + IdxW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_last) begin
                    cnt_next   = '0;
                    next_state = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_last) begin
                    tx_done_o = 1'b1;
                    cnt_next  = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        load_frame = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
        endcase

        if (load_frame) begin
            fifo_pop    = 1'b1;
            shift_next  = fifo_data;
            period_next = clks_clamped;
            cnt_next    = '0;
            next_state  = START;
`ifdef UART_TX_PARITY_EN
            parity_next = ^fifo_data;
`endif
        end

        // Line value follows the state being entered so it comes straight off a flop.
        unique case (next_state)
            START:   serial_next = 1'b0;
            DATA:    serial_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  serial_next = parity_next;
`endif
            default: serial_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed testbench for uart_transmitter. Samples are taken on the falling edge;
// sample index s relates to the first accepted byte's handshake edge N as the
// negedge after edge N-1+s, so the first start-bit cycle is sample 2.
module tb_uart_transmitter;

    localparam int unsigned FifoDepth = 4;
    localparam int unsigned CntW      = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int MaxS = 4096;

    logic            clk = 1'b0;
    logic            rst;
    logic [CntW-1:0] clks_per_bit;
    logic            serial;
    logic            busy;
    logic            done;

    uart_transmitter_if tif ();

    uart_transmitter #(
        .FifoDepth (FifoDepth),
        .CntW      (CntW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst),
        .CLKS_PER_BIT (clks_per_bit),
        .tx_if        (tif),
        .tx_serial_o  (serial),
        .tx_busy_o    (busy),
        .tx_done_o    (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    bit   rec   = 1'b0;
    int   nsamp = 0;
    logic line_s  [MaxS];
    logic done_s  [MaxS];
    logic ready_s [MaxS];
    logic busy_s  [MaxS];

    always @(negedge clk) begin
        if (!rec) begin
            nsamp <= 0;
        end else if (nsamp < MaxS) begin
            line_s[nsamp]  <= serial;
            done_s[nsamp]  <= done;
            ready_s[nsamp] <= tif.tx_ready_o;
            busy_s[nsamp]  <= busy;
            nsamp          <= nsamp + 1;
        end
    end

    // Expected stream: exp_n frames, byte exp_b[i] at period exp_p[i], back to back.
    logic [7:0] exp_b [8];
    int         exp_p [8];
    int         exp_n;

    function automatic logic exp_bit(input logic [7:0] b, input int p, input int k);
        int seg;
        seg = k / p;
        if (seg == 0) return 1'b0;
        if (seg <= 8) return b[seg-1];
`ifdef UART_TX_PARITY_EN
        if (seg == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic void exp_at(input int s, output logic ln, output logic dn);
        int k;
        int len;
        k  = s - 2;
        ln = 1'b1;
        dn = 1'b0;
        if (k < 0) return;
        for (int i = 0; i < exp_n; i++) begin
            len = FB * exp_p[i];
            if (k < len) begin
                ln = exp_bit(exp_b[i], exp_p[i], k);
                dn = (k == len - 1);
                return;
            end
            k = k - len;
        end
    endfunction

    function automatic int total_len();
        int t;
        t = 0;
        for (int i = 0; i < exp_n; i++) t = t + FB * exp_p[i];
        return t;
    endfunction

    // Number of samples in [0, n) whose line or done differs from the model.
    function automatic int stream_errs(input int n, output int first_bad);
        logic ln;
        logic dn;
        int   bad;
        bad       = 0;
        first_bad = -1;
        for (int s = 0; s < n; s++) begin
            exp_at(s, ln, dn);
            if (line_s[s] !== ln || done_s[s] !== dn) begin
                if (bad == 0) first_bad = s;
                bad++;
            end
        end
        return bad;
    endfunction

    function automatic int done_pulses(input int n);
        int c;
        c = 0;
        for (int s = 0; s < n; s++) if (done_s[s] === 1'b1) c++;
        return c;
    endfunction

    task automatic start_rec();
        rec = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rec = 1'b1;
    endtask

    task automatic wait_samples(input int n);
        int t;
        t = 0;
        while (nsamp < n && t < n + 200) begin
            @(posedge clk);
            t++;
        end
        checks++;
        if (nsamp < n) begin
            errors++;
            $display("FAIL sample_timeout: got %0d samples, want %0d", nsamp, n);
        end
    endtask

    // Call just after a posedge; returns just after the handshake edge.
    task automatic push(input logic [7:0] b, output int waited);
        tif.tx_valid_i = 1'b1;
        tif.tx_byte_i  = b;
        waited = 0;
        forever begin
            @(negedge clk);
            if (tif.tx_ready_o === 1'b1 || waited > 3000) break;
            waited++;
        end
        @(posedge clk);
        #1;
        tif.tx_valid_i = 1'b0;
        checks++;
        if (waited > 3000) begin
            errors++;
            $display("FAIL push_timeout: ready stayed low %0d cycles, want < 3000", waited);
        end
    endtask

    task automatic test_reset();
        int bad;
        int fb;
        rst = 1'b1;
        tif.tx_valid_i = 1'b0;
        tif.tx_byte_i  = 8'h00;
        clks_per_bit   = 16'd87;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (serial !== 1'b1) begin errors++; $display("FAIL reset_serial: got %b want 1", serial); end
        checks++;
        if (tif.tx_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", tif.tx_ready_o);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        start_rec();
        wait_samples(1000);
        exp_n = 0;
        bad = stream_errs(1000, fb);
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL idle_line: %0d bad samples first %0d, want 0", bad, fb);
        end
        checks++;
        if (busy_s[999] !== 1'b0) begin
            errors++; $display("FAIL idle_busy: got %b want 0", busy_s[999]);
        end
    endtask

    task automatic test_single();
        int w, bad, fb, tot;
        clks_per_bit = 16'd87;
        start_rec();
        push(8'h55, w);
        exp_n = 1; exp_b[0] = 8'h55; exp_p[0] = 87;
        tot = total_len();
        wait_samples(tot + 3);
        checks++;
        if (line_s[1] !== 1'b1 || line_s[2] !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: got %b%b want 10", line_s[1], line_s[2]);
        end
        checks++;
        if (busy_s[1] !== 1'b1) begin
            errors++; $display("FAIL single_busy: got %b want 1", busy_s[1]);
        end
        bad = stream_errs(tot + 3, fb);
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL single_frame: %0d bad samples first %0d, want 0", bad, fb);
        end
        checks++;
        if (done_s[tot + 1] !== 1'b1) begin
            errors++; $display("FAIL single_done_pos: got %b want 1", done_s[tot + 1]);
        end
        checks++;
        if (done_pulses(tot + 3) !== 1) begin
            errors++; $display("FAIL single_done_cnt: got %0d want 1", done_pulses(tot + 3));
        end
        checks++;
        if (busy_s[tot + 2] !== 1'b0) begin
            errors++; $display("FAIL single_idle_busy: got %b want 0", busy_s[tot + 2]);
        end
    endtask

    task automatic test_back_to_back();
        int w, bad, fb, tot;
        logic [7:0] bytes [4];
        bytes = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        clks_per_bit = 16'd4;
        start_rec();
        for (int i = 0; i < 4; i++) begin
            push(bytes[i], w);
            checks++;
            if (w !== 0) begin errors++; $display("FAIL b2b_ready_%0d: waited %0d want 0", i, w); end
            exp_b[i] = bytes[i];
            exp_p[i] = 4;
        end
        exp_n = 4;
        tot = total_len();
        wait_samples(tot + 3);
        bad = stream_errs(tot + 3, fb);
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL b2b_frames: %0d bad samples first %0d, want 0", bad, fb);
        end
        checks++;
        if (done_pulses(tot + 3) !== 4) begin
            errors++; $display("FAIL b2b_done_cnt: got %0d want 4", done_pulses(tot + 3));
        end
    endtask

    task automatic test_full();
        int w, bad, fb, tot, p;
        logic [7:0] bytes [6];
        bytes = '{8'h01, 8'h80, 8'h7E, 8'h81, 8'hC3, 8'h3C};
        clks_per_bit = 16'd4;
        p = 4;
        start_rec();
        for (int i = 0; i < 6; i++) begin
            push(bytes[i], w);
            exp_b[i] = bytes[i];
            exp_p[i] = p;
        end
        // 6th byte waits until the first STOP pop frees a slot.
        checks++;
        if (w !== FB * p - 3) begin
            errors++; $display("FAIL full_wait: waited %0d want %0d", w, FB * p - 3);
        end
        exp_n = 6;
        tot = total_len();
        wait_samples(tot + 3);
        checks++;
        if (ready_s[4] !== 1'b1 || ready_s[5] !== 1'b0) begin
            errors++;
            $display("FAIL full_ready_drop: got %b%b want 10", ready_s[4], ready_s[5]);
        end
        checks++;
        if (ready_s[FB * p + 1] !== 1'b0 || ready_s[FB * p + 2] !== 1'b1) begin
            errors++;
            $display("FAIL full_ready_rise: got %b%b want 01",
                     ready_s[FB * p + 1], ready_s[FB * p + 2]);
        end
        bad = stream_errs(tot + 3, fb);
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL full_frames: %0d bad samples first %0d, want 0", bad, fb);
        end
        checks++;
        if (done_pulses(tot + 3) !== 6) begin
            errors++; $display("FAIL full_done_cnt: got %0d want 6", done_pulses(tot + 3));
        end
    endtask

    task automatic test_clamp();
        int w, bad, fb, tot;
        clks_per_bit = 16'd1;
        start_rec();
        push(8'hC3, w);
        push(8'h5A, w);
        repeat (8) @(posedge clk);
        #1;
        clks_per_bit = 16'd10;
        exp_n = 2;
        exp_b[0] = 8'hC3; exp_p[0] = 2;
        exp_b[1] = 8'h5A; exp_p[1] = 10;
        tot = total_len();
        wait_samples(tot + 3);
        checks++;
        if (line_s[3] !== 1'b0 || line_s[4] !== 1'b1) begin
            errors++; $display("FAIL clamp_start: got %b%b want 01", line_s[3], line_s[4]);
        end
        bad = stream_errs(tot + 3, fb);
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL clamp_frames: %0d bad samples first %0d, want 0", bad, fb);
        end
        checks++;
        if (done_s[FB * 2 + 1] !== 1'b1) begin
            errors++; $display("FAIL clamp_done_pos: got %b want 1", done_s[FB * 2 + 1]);
        end
    endtask

    task automatic test_reset_mid();
        int w, bad_line, bad_busy, dn;
        clks_per_bit = 16'd8;
        start_rec();
        push(8'h07, w);
        push(8'hAA, w);
        repeat (34) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (serial !== 1'b1) begin errors++; $display("FAIL rstmid_serial: got %b want 1", serial); end
        checks++;
        if (tif.tx_ready_o !== 1'b1) begin
            errors++; $display("FAIL rstmid_ready: got %b want 1", tif.tx_ready_o);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        wait_samples(300);
        // Bit 2 of 0x07 is 1, bit 3 is 0: confirms the reset hit during bit 3.
        checks++;
        if (line_s[33] !== 1'b1 || line_s[35] !== 1'b0) begin
            errors++; $display("FAIL rstmid_pre: got %b%b want 10", line_s[33], line_s[35]);
        end
        bad_line = 0;
        bad_busy = 0;
        for (int s = 37; s < 300; s++) begin
            if (line_s[s] !== 1'b1) bad_line++;
            if (busy_s[s] !== 1'b0) bad_busy++;
        end
        checks++;
        if (bad_line !== 0) begin
            errors++; $display("FAIL rstmid_line: %0d low samples, want 0", bad_line);
        end
        checks++;
        if (bad_busy !== 0) begin
            errors++; $display("FAIL rstmid_flush: %0d busy samples, want 0", bad_busy);
        end
        dn = done_pulses(300);
        checks++;
        if (dn !== 0) begin errors++; $display("FAIL rstmid_done: got %0d want 0", dn); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int w, bad, fb, tot;
        clks_per_bit = 16'd4;
        start_rec();
        push(8'h07, w);
        exp_n = 1; exp_b[0] = 8'h07; exp_p[0] = 4;
        tot = total_len();
        wait_samples(tot + 3);
        checks++;
        if (line_s[2 + 9 * 4 + 1] !== 1'b1) begin
            errors++; $display("FAIL parity_bit: got %b want 1", line_s[2 + 9 * 4 + 1]);
        end
        bad = stream_errs(tot + 3, fb);
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL parity_frame: %0d bad samples first %0d, want 0", bad, fb);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_clamp();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
